// File: rtl/design_slot_mux_if.sv
// ============================================================================
// design_slot_mux_if : Wishbone slave bus bundle for design_slot_mux
// Rev 1.0
// ============================================================================
`default_nettype none

interface design_slot_mux_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

`default_nettype wire

// File: rtl/design_slot_mux.sv
// ============================================================================
// design_slot_mux : Wishbone-selected tenant pad mux with timed isolation window
// Optional macro SWITCH_IRQ_EN adds the sticky switch_irq output. Rev 1.0
// ============================================================================
`default_nettype none

module design_slot_mux #(
    parameter int          NUM_DESIGNS = 5,
    parameter int          IO_W        = 33,
    parameter int          RST_HOLD    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    design_slot_mux_if.slave            wb,
    input  logic [NUM_DESIGNS*IO_W-1:0] design_do,
    input  logic [NUM_DESIGNS*IO_W-1:0] design_oeb,
    output logic [NUM_DESIGNS-1:0]      design_rst_n,
    output logic [IO_W-1:0]             io_out,
    output logic [IO_W-1:0]             io_oeb,
    output logic [31:0]                 custom_settings
`ifdef SWITCH_IRQ_EN
    ,
    output logic                        switch_irq
`endif
);

    localparam int SEL_W = $clog2(NUM_DESIGNS + 1);
    localparam int CNT_W = $clog2(RST_HOLD);

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_ISOLATE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam logic [SEL_W-1:0] IDX_NONE = SEL_W'(NUM_DESIGNS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_HOLD - 1);

    logic [1:0]       state;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] active;
    logic [CNT_W-1:0] count;
    logic [31:0]      custom;
    logic             ack;
    logic [31:0]      rdat;
    logic             irq;

    logic             hit;
    logic             accept;
    logic             ctrl_wr;
    logic             cust_wr;
    logic [31:0]      status;
    logic [31:0]      rd_mux;
    logic             unused_adr;

    assign unused_adr = ^wb.wbs_adr_i[1:0];

    // A transaction is accepted only while ack is low, so ack can never repeat back to back.
    assign hit     = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept  = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack;
    assign ctrl_wr = accept & wb.wbs_we_i & (wb.wbs_adr_i[3:2] == 2'd0) & wb.wbs_sel_i[0];
    assign cust_wr = accept & wb.wbs_we_i & (wb.wbs_adr_i[3:2] == 2'd1);

`ifdef SWITCH_IRQ_EN
    assign switch_irq = irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        status              = '0;
        status[SEL_W-1:0]   = active;
        status[8]           = (state == ST_ISOLATE);
        status[9]           = irq;
        status[23:16]       = 8'(count);
    end

    always_comb begin
        case (wb.wbs_adr_i[3:2])
            2'd0:    rd_mux = 32'(target);
            2'd1:    rd_mux = custom;
            2'd2:    rd_mux = status;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= ST_NONE;
            target <= IDX_NONE;
            active <= IDX_NONE;
            count  <= '0;
            custom <= 32'd0;
            ack    <= 1'b0;
            rdat   <= 32'd0;
`ifdef SWITCH_IRQ_EN
            irq    <= 1'b0;
`endif
        end else begin
            ack  <= accept;
            rdat <= accept ? rd_mux : 32'd0;

            if (cust_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb.wbs_sel_i[b]) custom[8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
                end
            end

            // Any CTRL write restarts the window, even mid-window or for the running slot.
            if (ctrl_wr) begin
                target <= wb.wbs_dat_i[SEL_W-1:0];
                state  <= ST_ISOLATE;
                count  <= CNT_LOAD;
                active <= IDX_NONE;
`ifdef SWITCH_IRQ_EN
                irq    <= 1'b0;
`endif
            end else if (state == ST_ISOLATE) begin
                if (count == '0) begin
                    if (target < IDX_NONE) begin
                        state  <= ST_RUN;
                        active <= target;
                    end else begin
                        state  <= ST_NONE;
                        active <= IDX_NONE;
                    end
`ifdef SWITCH_IRQ_EN
                    irq    <= 1'b1;
`endif
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Reset release and pad hand-over share the same state/active registers, so they move together.
    always_comb begin
        io_out       = '0;
        io_oeb       = '1;
        design_rst_n = '0;
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            if ((state == ST_RUN) && (active == SEL_W'(k))) begin
                io_out          = design_do[k*IO_W +: IO_W];
                io_oeb          = design_oeb[k*IO_W +: IO_W];
                design_rst_n[k] = 1'b1;
            end
        end
    end

    assign custom_settings = custom;
    assign wb.wbs_ack_o    = ack;
    assign wb.wbs_dat_o    = rdat;

endmodule

`default_nettype wire

// File: tb/tb_design_slot_mux.sv
// ============================================================================
// tb_design_slot_mux : directed self-checking bench for design_slot_mux
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_design_slot_mux;

    localparam int ND = 4;
    localparam int IW = 33;
    localparam int RH = 8;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_CUSTOM = 32'h3000_0004;
    localparam logic [31:0] A_STATUS = 32'h3000_0008;
    localparam logic [31:0] A_RSV    = 32'h3000_000C;
    localparam logic [IW-1:0] ONES   = '1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IW-1:0]   do_slot  [ND];
    logic [IW-1:0]   oeb_slot [ND];
    logic [ND*IW-1:0] design_do;
    logic [ND*IW-1:0] design_oeb;
    logic [ND-1:0]   design_rst_n;
    logic [IW-1:0]   io_out;
    logic [IW-1:0]   io_oeb;
    logic [31:0]     custom_settings;
    logic [31:0]     rd;
    int              total = 0;
    int              bad   = 0;
`ifdef SWITCH_IRQ_EN
    logic            switch_irq;
`endif

    design_slot_mux_if wb ();

    assign design_do  = {do_slot[3], do_slot[2], do_slot[1], do_slot[0]};
    assign design_oeb = {oeb_slot[3], oeb_slot[2], oeb_slot[1], oeb_slot[0]};

    design_slot_mux #(
        .NUM_DESIGNS(ND),
        .IO_W       (IW),
        .RST_HOLD   (RH),
        .BASE_ADDR  (32'h3000_0000)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb             (wb),
        .design_do      (design_do),
        .design_oeb     (design_oeb),
        .design_rst_n   (design_rst_n),
        .io_out         (io_out),
        .io_oeb         (io_oeb),
        .custom_settings(custom_settings)
`ifdef SWITCH_IRQ_EN
        ,
        .switch_irq     (switch_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        rdata = 32'd0;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
        for (int i = 0; i < 16 && !got; i++) begin
            step();
            if (wb.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                rdata = wb.wbs_dat_o;
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL wb_ack_timeout adr=%h got=no_ack exp=ack", adr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++;
        if (io_oeb !== ONES || design_rst_n !== 4'b0000 || io_out !== '0) begin
            bad++;
            $display("FAIL reset_pads got oeb=%h rst_n=%b out=%h exp oeb=all1 rst_n=0000 out=0",
                     io_oeb, design_rst_n, io_out);
        end
        total++;
        if (wb.wbs_ack_o !== 1'b0 || wb.wbs_dat_o !== 32'd0 || custom_settings !== 32'd0) begin
            bad++;
            $display("FAIL reset_wb got ack=%b dat=%h cust=%h exp 0 0 0",
                     wb.wbs_ack_o, wb.wbs_dat_o, custom_settings);
        end
        rst = 1'b0;
        step();
        wb_xfer(1'b0, A_STATUS, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h0000_0004) begin
            bad++;
            $display("FAIL reset_status got=%h exp=00000004", rd);
        end
    endtask

    task automatic test_switch();
        wb_xfer(1'b1, A_CTRL, 32'd2, 4'h1, rd);
        for (int i = 0; i < RH; i++) begin
            if (i > 0) step();
            total++;
            if (io_oeb !== ONES || design_rst_n !== 4'b0000 || io_out !== '0) begin
                bad++;
                $display("FAIL switch_isolate cyc=%0d got oeb=%h rst_n=%b exp oeb=all1 rst_n=0000",
                         i, io_oeb, design_rst_n);
            end
`ifdef SWITCH_IRQ_EN
            total++;
            if (switch_irq !== 1'b0) begin
                bad++;
                $display("FAIL switch_irq_low cyc=%0d got=%b exp=0", i, switch_irq);
            end
`endif
        end
        step();
        total++;
        if (design_rst_n !== 4'b0100 || io_out !== do_slot[2] || io_oeb !== oeb_slot[2]) begin
            bad++;
            $display("FAIL switch_run2 got rst_n=%b out=%h oeb=%h exp rst_n=0100 out=%h oeb=%h",
                     design_rst_n, io_out, io_oeb, do_slot[2], oeb_slot[2]);
        end
`ifdef SWITCH_IRQ_EN
        total++;
        if (switch_irq !== 1'b1) begin
            bad++;
            $display("FAIL switch_irq_set got=%b exp=1", switch_irq);
        end
`endif
        do_slot[2] = 33'h1_2345_6789;
        #1;
        total++;
        if (io_out !== 33'h1_2345_6789) begin
            bad++;
            $display("FAIL switch_comb_path got=%h exp=123456789", io_out);
        end
    endtask

    task automatic test_retrigger();
        logic leak;
        leak = 1'b0;
        wb_xfer(1'b1, A_CTRL, 32'd1, 4'h1, rd);
        repeat (4) begin
            step();
            if (design_rst_n !== 4'b0000) leak = 1'b1;
        end
        wb_xfer(1'b1, A_CTRL, 32'd1, 4'h1, rd);
        repeat (3) begin
            step();
            if (design_rst_n !== 4'b0000) leak = 1'b1;
        end
        wb_xfer(1'b1, A_CTRL, 32'd1, 4'h1, rd);
        if (design_rst_n !== 4'b0000) leak = 1'b1;
        wb_xfer(1'b0, A_STATUS, 32'd0, 4'hF, rd);
        total++;
        if ((rd & 32'h00FF_0100) !== 32'h0006_0100) begin
            bad++;
            $display("FAIL retrig_count got=%h exp=(busy,count6)00060100", rd & 32'h00FF_0100);
        end
        repeat (5) begin
            if (design_rst_n !== 4'b0000 || io_oeb !== ONES) leak = 1'b1;
            step();
        end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL retrig_isolate got=reset_high_in_window exp=all_low");
        end
        total++;
        if (design_rst_n !== 4'b0000) begin
            bad++;
            $display("FAIL retrig_last_window got rst_n=%b exp=0000", design_rst_n);
        end
        step();
        total++;
        if (design_rst_n !== 4'b0010 || io_out !== do_slot[1] || io_oeb !== oeb_slot[1]) begin
            bad++;
            $display("FAIL retrig_run1 got rst_n=%b out=%h exp rst_n=0010 out=%h",
                     design_rst_n, io_out, do_slot[1]);
        end
    endtask

    task automatic test_custom();
        logic seen;
        wb_xfer(1'b1, A_CUSTOM, 32'hFFFF_FFFF, 4'b0101, rd);
        total++;
        if (custom_settings !== 32'h00FF_00FF) begin
            bad++;
            $display("FAIL custom_mask got=%h exp=00ff00ff", custom_settings);
        end
        wb_xfer(1'b0, A_CUSTOM, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h00FF_00FF) begin
            bad++;
            $display("FAIL custom_read got=%h exp=00ff00ff", rd);
        end
        wb_xfer(1'b1, A_RSV, 32'hDEAD_BEEF, 4'hF, rd);
        wb_xfer(1'b0, A_RSV, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0 || custom_settings !== 32'h00FF_00FF) begin
            bad++;
            $display("FAIL reserved got rd=%h cust=%h exp rd=0 cust=00ff00ff", rd, custom_settings);
        end
        wb_xfer(1'b1, A_CTRL, 32'd0, 4'b1110, rd);
        step(); step(); step();
        total++;
        if (design_rst_n !== 4'b0010) begin
            bad++;
            $display("FAIL ctrl_lane0_clear got rst_n=%b exp=0010", design_rst_n);
        end
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = A_CUSTOM; wb.wbs_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (wb.wbs_ack_o !== ((i % 2) == 0) ||
                wb.wbs_dat_o !== (((i % 2) == 0) ? 32'h00FF_00FF : 32'd0)) begin
                bad++;
                $display("FAIL held_strobe cyc=%0d got ack=%b dat=%h exp ack=%b", i,
                         wb.wbs_ack_o, wb.wbs_dat_o, (i % 2) == 0);
            end
        end
        wb.wbs_adr_i = 32'h4000_0004;
        seen = 1'b0;
        repeat (6) begin
            step();
            if (wb.wbs_ack_o !== 1'b0) seen = 1'b1;
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        total++;
        if (seen) begin
            bad++;
            $display("FAIL bad_base got=ack exp=no_ack");
        end
        step();
    endtask

    task automatic test_invalid();
        wb_xfer(1'b1, A_CTRL, 32'd7, 4'h1, rd);
        for (int i = 0; i < RH; i++) begin
            if (i > 0) step();
            total++;
            if (io_oeb !== ONES || design_rst_n !== 4'b0000) begin
                bad++;
                $display("FAIL invalid_isolate cyc=%0d got oeb=%h rst_n=%b exp all1 0000",
                         i, io_oeb, design_rst_n);
            end
`ifdef SWITCH_IRQ_EN
            total++;
            if (switch_irq !== 1'b0) begin
                bad++;
                $display("FAIL invalid_irq_clear cyc=%0d got=%b exp=0", i, switch_irq);
            end
`endif
        end
        step();
`ifdef SWITCH_IRQ_EN
        total++;
        if (switch_irq !== 1'b1) begin
            bad++;
            $display("FAIL invalid_irq_exit got=%b exp=1", switch_irq);
        end
`endif
        wb_xfer(1'b0, A_STATUS, 32'd0, 4'hF, rd);
        total++;
`ifdef SWITCH_IRQ_EN
        if (rd !== 32'h0000_0204 || design_rst_n !== 4'b0000) begin
            bad++;
            $display("FAIL invalid_none got status=%h rst_n=%b exp 00000204 0000", rd, design_rst_n);
        end
`else
        if (rd !== 32'h0000_0004 || design_rst_n !== 4'b0000) begin
            bad++;
            $display("FAIL invalid_none got status=%h rst_n=%b exp 00000004 0000", rd, design_rst_n);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic resumed;
        resumed = 1'b0;
        wb_xfer(1'b1, A_CTRL, 32'd3, 4'h1, rd);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wb_xfer(1'b0, A_STATUS, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'h0000_0004) begin
            bad++;
            $display("FAIL reset_mid_status got=%h exp=00000004", rd);
        end
        repeat (12) begin
            step();
            if (design_rst_n !== 4'b0000 || io_oeb !== ONES) resumed = 1'b1;
        end
        total++;
        if (resumed) begin
            bad++;
            $display("FAIL reset_mid_resume got=slot_released exp=none");
        end
        wb_xfer(1'b0, A_CUSTOM, 32'd0, 4'hF, rd);
        total++;
        if (rd !== 32'd0 || custom_settings !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_custom got rd=%h cust=%h exp 0 0", rd, custom_settings);
        end
`ifdef SWITCH_IRQ_EN
        total++;
        if (switch_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_irq got=%b exp=0", switch_irq);
        end
`endif
    endtask

    initial begin
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'd0; wb.wbs_dat_i = 32'd0;
        for (int k = 0; k < ND; k++) begin
            do_slot[k]  = {1'b1, 32'h1111_1111 * (k + 1)};
            oeb_slot[k] = {1'b0, 28'h0F0F_000, 4'(k)};
        end
        test_reset();
        test_switch();
        test_retrigger();
        test_custom();
        test_invalid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
